// File: rtl/bus_arbiter_8.sv
// ---------------------------------------------------------------------------
// bus_arbiter_8
//
// Round-robin arbiter for eight sources sharing one 16-bit common bus. The
// winner drives the select of the 8x1 bus mux. An owner may keep the bus
// while it keeps requesting, but once another source is waiting it is limited
// to MAX_HOLD consecutive grant cycles before the bus is handed on.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles while another source waits
//              (legal range 1..15)
//
// Ports
//   Clock      in   1  rising-edge clock for all state
//   Reset      in   1  synchronous, active-high reset
//   Request    in   8  Request[i] high: source i wants the bus
//   Grant      out  8  one-hot bus owner, all-zero when idle (registered)
//   Selection  out  3  binary index of the owner, 0 when idle (registered)
//   Bus_valid  out  1  high whenever Grant is non-zero (registered)
// ---------------------------------------------------------------------------
module bus_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Request,
  output logic [7:0] Grant,
  output logic [2:0] Selection,
  output logic       Bus_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  logic [3:0] pick_s;
  logic       pick_found_s;
  logic [2:0] pick_idx_s;
  logic       owner_req_s;
  logic       others_req_s;

  // First requester in the order base+1, base+2, ..., base (mod 8).
  // Result is {found, index}. Scanning from the far end lets the nearest
  // requester overwrite later ones, so no early exit is needed.
  function automatic logic [3:0] rr_pick(input logic [2:0] base,
                                         input logic [7:0] req);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Decode the round-robin candidate and the owner/other-request status.
  always_comb begin
    pick_s       = rr_pick(last_q, Request);
    pick_found_s = pick_s[3];
    pick_idx_s   = pick_s[2:0];
    owner_req_s  = |(Request & grant_q);
    others_req_s = |(Request & ~grant_q);
  end

  // Next-state and next-output computation for the two-state controller.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = OWNED;
          last_d  = pick_idx_s;
          hold_d  = 4'd1;
          grant_d = 8'd1 << pick_idx_s;
          sel_d   = pick_idx_s;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          grant_d = 8'h00;
          sel_d   = 3'd0;
          valid_d = 1'b0;
        end
      end

      OWNED: begin
        if (Request == 8'h00) begin
          // Bus released; Last is kept so fairness carries across idle gaps.
          state_d = IDLE;
          hold_d  = 4'd0;
          grant_d = 8'h00;
          sel_d   = 3'd0;
          valid_d = 1'b0;
        end else if (owner_req_s && (!others_req_s || (hold_q < HOLD_MAX))) begin
          // Owner keeps the bus; counter saturates so a lone owner never
          // overflows it and is handed off immediately once someone arrives.
          state_d = OWNED;
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 4'd1;
          end else begin
            hold_d = hold_q;
          end
        end else begin
          // Owner dropped or used up its share: hand off with no idle cycle.
          // Since another source is requesting, the pick can never be the
          // owner itself (the owner is last in its own search order).
          state_d = OWNED;
          last_d  = pick_idx_s;
          hold_d  = 4'd1;
          grant_d = 8'd1 << pick_idx_s;
          sel_d   = pick_idx_s;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        hold_d  = 4'd0;
        grant_d = 8'h00;
        sel_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset taking priority.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      hold_q  <= 4'd0;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign Grant     = grant_q;
  assign Selection = sel_q;
  assign Bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_8
//
// Self-checking bench for bus_arbiter_8. A behavioural model (owner index,
// last owner, consecutive-grant count, all plain integers) predicts the
// outputs each cycle; a negedge compare process checks the DUT against it.
// Directed sequences with literal expectations pin the model, followed by a
// randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_8;

  localparam int MAXH = 4;

  logic       Clock;
  logic       Reset;
  logic [7:0] Request;
  logic [7:0] Grant;
  logic [2:0] Selection;
  logic       Bus_valid;

  int vectors = 0;
  int miscompares = 0;

  // Model state: owner is -1 when the bus is idle.
  int m_owner = -1;
  int m_last  = 7;
  int m_hold  = 0;
  bit m_init  = 1'b0;

  bus_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Request   (Request),
    .Grant     (Grant),
    .Selection (Selection),
    .Bus_valid (Bus_valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model, evaluated on the same edges the DUT samples.
  always @(posedge Clock) begin
    int  pick;
    bit  others;
    if (Reset) begin
      m_owner = -1;
      m_last  = 7;
      m_hold  = 0;
      m_init  = 1'b1;
    end else if (m_init) begin
      others = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (Request[i] && i != m_owner) others = 1'b1;
      end
      if (Request == 8'h00) begin
        m_owner = -1;
        m_hold  = 0;
      end else if (m_owner >= 0 && Request[m_owner] && (!others || m_hold < MAXH)) begin
        if (m_hold < MAXH) m_hold = m_hold + 1;
      end else begin
        pick = -1;
        for (int k = 1; k <= 8; k++) begin
          if (pick < 0 && Request[(m_last + k) % 8]) pick = (m_last + k) % 8;
        end
        m_owner = pick;
        m_last  = pick;
        m_hold  = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (m_init) begin
      chk("model_grant", int'(Grant), (m_owner < 0) ? 0 : (1 << m_owner));
      chk("model_sel", int'(Selection), (m_owner < 0) ? 0 : m_owner);
      chk("model_valid", int'(Bus_valid), (m_owner < 0) ? 0 : 1);
    end
  end

  // Drive one cycle of inputs at the negedge, then wait past the next posedge.
  task automatic apply(input logic rst, input logic [7:0] req);
    @(negedge Clock);
    Reset   = rst;
    Request = req;
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] g,
                            input logic [2:0] s, input logic v);
    chk({name, "_grant"}, int'(Grant), int'(g));
    chk({name, "_sel"}, int'(Selection), int'(s));
    chk({name, "_valid"}, int'(Bus_valid), int'(v));
  endtask

  initial begin
    Reset   = 1'b1;
    Request = 8'h00;

    // Reset state
    apply(1'b1, 8'h00);
    expect_out("reset", 8'h00, 3'd0, 1'b0);

    // Idle stays idle
    apply(1'b0, 8'h00);
    expect_out("idle", 8'h00, 3'd0, 1'b0);

    // Single requester, 1-cycle latency
    apply(1'b0, 8'h04);
    expect_out("req04", 8'h04, 3'd2, 1'b1);

    // Two-way alternation with MAX_HOLD=4, no gap cycles
    apply(1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 8'h81);
      expect_out("alt_src0", 8'h01, 3'd0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 8'h81);
      expect_out("alt_src7", 8'h80, 3'd7, 1'b1);
    end
    apply(1'b0, 8'h81);
    expect_out("alt_back0", 8'h01, 3'd0, 1'b1);

    // Lone requester held indefinitely
    apply(1'b1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, 8'h10);
      expect_out("lone10", 8'h10, 3'd4, 1'b1);
    end

    // Owner 3 drops while source 5 waits
    apply(1'b1, 8'h00);
    apply(1'b0, 8'h08);
    expect_out("own3", 8'h08, 3'd3, 1'b1);
    apply(1'b0, 8'h20);
    expect_out("handoff5", 8'h20, 3'd5, 1'b1);

    // Release to idle, then all request: next after Last=5 is 6
    apply(1'b0, 8'h00);
    expect_out("release", 8'h00, 3'd0, 1'b0);
    apply(1'b0, 8'hFF);
    expect_out("resume6", 8'h40, 3'd6, 1'b1);

    // Reset mid-grant of source 6, then source 0 first
    apply(1'b1, 8'hFF);
    expect_out("midreset", 8'h00, 3'd0, 1'b0);
    apply(1'b0, 8'hFF);
    expect_out("after_reset", 8'h01, 3'd0, 1'b1);

    // Randomized phase checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      logic       rs;
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2:       r = 8'($urandom) & 8'($urandom);
        default: r = 8'($urandom);
      endcase
      // Hold a pattern for a few cycles to exercise the hold counter.
      rs = ($urandom_range(0, 99) == 0);
      for (int h = $urandom_range(1, 7); h > 0; h--) begin
        apply(rs, r);
        rs = 1'b0;
      end
    end

    @(negedge Clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
